oam_dma_ctrl: RTL
=================

// Module: oam_dma_ctrl
// PURPOSE
//  Sprite-DMA controller and bus arbiter between the 6502 CPU core and the system bus.
//  A CPU write to $4014 latches a source page and halts the CPU through cpu_rdy.
//  The block then owns the bus and copies 256 bytes from $PP00-$PPFF to the OAM data
//  port ($2004), one read/write pair per byte. Bus ownership returns to the CPU afterwards.
//  Sits between CPU Addr_bus/Data_bus_out/R_nW and the memory/PPU decode.
// PARAMETERS
//  DMA_REG_ADDR   16'h4014  CPU write address that triggers DMA (data byte = source page)
//  OAM_DATA_ADDR  16'h2004  destination address written once per byte
//  XFER_LEN       256       bytes per transfer; must be a power of two, <= 256
// PORTS
//  clk_ph1      in   1   single system clock; all state updates on posedge
//  rst          in   1   asynchronous reset, active-high
//  cpu_addr     in   16  CPU address bus
//  cpu_dout     in   8   CPU write data
//  cpu_r_nw     in   1   CPU read(1)/write(0)
//  bus_din      in   8   read data returned from the system bus
//  bus_addr     out  16  arbitrated address to memory/PPU decode
//  bus_dout     out  8   arbitrated write data
//  bus_r_nw     out  1   arbitrated read/write strobe
//  cpu_rdy      out  1   1 = CPU may advance; 0 = CPU holds its current cycle
//  dma_active   out  1   1 while the DMA owns the bus (READ or WRITE state)
// BEHAVIOUR
//  Reset (async): state=IDLE, cpu_rdy=1, dma_active=0, page=0, idx=0, data_latch=0,
//   cyc_odd=0. Bus outputs pass the CPU through (CPU owns the bus in reset).
//  cyc_odd toggles every clock from reset and is the global even/odd cycle marker.
//  States: IDLE, HALT, ALIGN, READ, WRITE. cpu_rdy and dma_active are registered.
//  IDLE: bus = CPU. When cpu_r_nw=0 and cpu_addr=DMA_REG_ADDR: page<=cpu_dout, idx<=0,
//   cpu_rdy<=0, go HALT.
//  HALT: bus = CPU. If cpu_r_nw=0 (CPU write cycles cannot be stalled), stay.
//   Otherwise the halt has taken effect (the CPU repeats this read):
//   go READ if cyc_odd=1 (next cycle is even), else go ALIGN.
//  ALIGN: one dummy cycle, bus = CPU (repeated read, harmless); go READ.
//  READ (always on an even cycle): bus_addr={page,idx}, bus_r_nw=1, dma_active=1;
//   data_latch<=bus_din at cycle end; go WRITE.
//  WRITE: bus_addr=OAM_DATA_ADDR, bus_dout=data_latch, bus_r_nw=0.
//   If idx=XFER_LEN-1: cpu_rdy<=1, dma_active<=0, go IDLE. Else idx<=idx+1, go READ.
//  Bus mux output is combinational from the state. DMA drives the bus only in READ/WRITE.
//  Stall length = 1 halt + 0/1 align + 2*XFER_LEN cycles (513 or 514 for 256 bytes).
//  idx is 8 bits. A source page of $FF reads $FF00-$FFFF with no carry into the page.
//  $4014 writes seen outside IDLE are ignored. No re-trigger; the CPU is halted anyway.
//  A CPU write to $4014 in the same cycle as the final WRITE is impossible (CPU halted).
//  Reset mid-transfer: immediate IDLE, cpu_rdy=1. The partial OAM contents are left as-is.
// CONFIGURATION
//  OAM_DMA_PARITY_EN defined: ALIGN is inserted only when needed (cycle parity above).
//  Not defined: cyc_odd is unused and HALT->ALIGN->READ is always taken.
//   The stall is then a fixed 2*XFER_LEN+2 cycles.
// STRUCTURE
//  Shared package/include nes_bus_defs: $4014/$2004 address constants and the DMA state
//   encoding localparams (also used by the CPU and PPU tops).
//  One sub-module: oam_dma_bus_mux. It is combinational and selects CPU vs DMA
//   addr/data/r_nw from the state. The FSM, counters and latch stay in oam_dma_ctrl.
// TESTING
//  1 Reset mid-copy: assert rst at byte 37 -> outputs go to reset values within the same
//    cycle; the next $4014 write restarts cleanly from idx=0.
//  2 Write $02 to $4014, CPU read next cycle, even alignment -> cpu_rdy low for 513
//    cycles; reads $0200..$02FF are followed by writes to $2004 of the same bytes, in order.
//  3 Same trigger with odd alignment -> exactly one ALIGN cycle, 514-cycle stall.
//    Without OAM_DMA_PARITY_EN, both cases stall exactly 514 cycles.
//  4 Trigger while the CPU performs 3 consecutive write cycles (BRK push) -> HALT holds
//    for 3 cycles, the bus stays with the CPU, and the DMA begins on the first read cycle.
//  5 Page $FF with bus_din=addr[7:0] -> the last read address is $FFFF and the last $2004
//    write data is $FF; cpu_rdy returns to 1 the cycle after.
//  6 Second $4014 write during HALT/READ (forced on cpu_* inputs) -> ignored;
//    page and byte count are unchanged.

Source files
------------

// File: rtl/nes_bus_defs_pkg.sv
// nes_bus_defs: bus address constants and sprite-DMA state encoding shared by the CPU, PPU and DMA tops.
package nes_bus_defs;
   localparam logic [15:0] NES_DMA_REG_ADDR  = 16'h4014;
   localparam logic [15:0] NES_OAM_DATA_ADDR = 16'h2004;
   localparam int          NES_XFER_LEN      = 256;
   typedef enum logic [2:0] {DMA_IDLE, DMA_HALT, DMA_ALIGN, DMA_READ, DMA_WRITE} dma_state_t;
   function automatic logic dma_owns_bus(input dma_state_t s);
      return (s == DMA_READ) || (s == DMA_WRITE);
   endfunction
endpackage

// File: rtl/oam_dma_bus_mux.sv
// oam_dma_bus_mux: selects CPU or sprite-DMA address/data/strobe onto the system bus from the DMA state.
module oam_dma_bus_mux
   import nes_bus_defs::*;
#(
   parameter logic [15:0] OAM_DATA_ADDR = NES_OAM_DATA_ADDR
) (
   input  dma_state_t  state,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_r_nw,
   input  logic [7:0]  page,
   input  logic [7:0]  idx,
   input  logic [7:0]  data_latch,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_dout,
   output logic        bus_r_nw
);
   always_comb begin
      bus_addr = state == DMA_READ ? {page, idx} : state == DMA_WRITE ? OAM_DATA_ADDR : cpu_addr;
      bus_dout = state == DMA_WRITE ? data_latch : cpu_dout;
      bus_r_nw = state == DMA_READ ? 1'b1 : state == DMA_WRITE ? 1'b0 : cpu_r_nw;
   end
endmodule

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: $4014 sprite-DMA controller; halts the CPU and copies one page to $2004.
// Define OAM_DMA_PARITY_EN to skip the ALIGN cycle when the halt already lands on an odd cycle.
module oam_dma_ctrl
   import nes_bus_defs::*;
#(
   parameter logic [15:0] DMA_REG_ADDR  = NES_DMA_REG_ADDR,
   parameter logic [15:0] OAM_DATA_ADDR = NES_OAM_DATA_ADDR,
   parameter int          XFER_LEN      = NES_XFER_LEN
) (
   input  logic        clk_ph1,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   input  logic        cpu_r_nw,
   input  logic [7:0]  bus_din,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_dout,
   output logic        bus_r_nw,
   output logic        cpu_rdy,
   output logic        dma_active
);
   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);
   dma_state_t state, state_nxt;
   logic [7:0] page, idx, data_latch;
   logic       skip_align;
`ifdef OAM_DMA_PARITY_EN
   logic cyc_odd;
   always_ff @(posedge clk_ph1 or posedge rst)
      if (rst) cyc_odd <= 1'b0;
      else cyc_odd <= ~cyc_odd;
   assign skip_align = cyc_odd;
`else
   assign skip_align = 1'b0;
`endif
   always_comb begin
      state_nxt = state;
      case (state)
         DMA_IDLE:  state_nxt = (!cpu_r_nw && cpu_addr == DMA_REG_ADDR) ? DMA_HALT : DMA_IDLE;
         DMA_HALT:  state_nxt = !cpu_r_nw ? DMA_HALT : skip_align ? DMA_READ : DMA_ALIGN;
         DMA_ALIGN: state_nxt = DMA_READ;
         DMA_READ:  state_nxt = DMA_WRITE;
         DMA_WRITE: state_nxt = idx == LAST_IDX ? DMA_IDLE : DMA_READ;
         default:   state_nxt = DMA_IDLE;
      endcase
   end
   // cpu_rdy/dma_active are registered copies of what the next state implies
   always_ff @(posedge clk_ph1 or posedge rst)
      if (rst) begin
         state      <= DMA_IDLE;
         cpu_rdy    <= 1'b1;
         dma_active <= 1'b0;
         page       <= '0;
         idx        <= '0;
         data_latch <= '0;
      end else begin
         state      <= state_nxt;
         cpu_rdy    <= state_nxt == DMA_IDLE;
         dma_active <= dma_owns_bus(state_nxt);
         if (state == DMA_IDLE && state_nxt == DMA_HALT) begin
            page <= cpu_dout;
            idx  <= '0;
         end
         if (state == DMA_READ) data_latch <= bus_din;
         if (state == DMA_WRITE && state_nxt == DMA_READ) idx <= idx + 8'd1;
      end
   oam_dma_bus_mux #(.OAM_DATA_ADDR(OAM_DATA_ADDR)) u_mux (
      .state      (state),
      .cpu_addr   (cpu_addr),
      .cpu_dout   (cpu_dout),
      .cpu_r_nw   (cpu_r_nw),
      .page       (page),
      .idx        (idx),
      .data_latch (data_latch),
      .bus_addr   (bus_addr),
      .bus_dout   (bus_dout),
      .bus_r_nw   (bus_r_nw)
   );
endmodule
